fir_tap_regfile: RTL and testbench
==================================

FIR_TAP_REGFILE -- requirements
Module: fir_tap_regfile

Interface
REQ-001 SHALL have parameter DATA_W, default 16, entry width in bits; a multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries (filter length); DEPTH >= 2.
REQ-003 SHALL have parameter ADDR_W, default 3, address width; 2**ADDR_W >= DEPTH.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port wr_en  input  1  addressed write request.
REQ-007 SHALL have port wr_addr  input  ADDR_W  write entry index.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port wr_be  input  DATA_W/8  byte-lane enables; bit k enables bits [8k+7:8k].
REQ-010 SHALL have port shift_en  input  1  delay-line shift request.
REQ-011 SHALL have port shift_in  input  DATA_W  new sample entering entry 0.
REQ-012 SHALL have port rd_en  input  1  read request for both read ports.
REQ-013 SHALL have ports laddr, raddr  input  ADDR_W  left/right read indices.
REQ-014 SHALL have ports lout, rout  output  DATA_W  registered read data.
REQ-015 SHALL have port rd_valid  output  1  lout/rout hold data for the previous cycle's rd_en.
REQ-016 SHALL have port fill_cnt  output  ADDR_W+1  samples shifted in since reset, saturating at DEPTH.
REQ-017 SHALL have port full  output  1  high when fill_cnt == DEPTH.
REQ-018 SHALL have port addr_err  output  1  one-cycle pulse on an out-of-range access.

Function
REQ-019 SHALL store DEPTH entries of DATA_W bits, indices 0..DEPTH-1.
REQ-020 SHALL, on shift_en, move entry i to entry i+1 for i = 0..DEPTH-2, load shift_in into entry 0, and discard old entry DEPTH-1.
REQ-021 SHALL, on wr_en with wr_addr < DEPTH, update only the byte lanes of entry wr_addr whose wr_be bit is 1; other lanes keep their value.
REQ-022 SHALL, when shift_en and wr_en are both active, apply the shift first and then the byte-lane write to the post-shift entry wr_addr (write wins on that entry).
REQ-023 SHALL, on rd_en, register lout = entry[laddr] and rout = entry[raddr] from the pre-edge array contents (read-before-write); data visible the cycle after rd_en.
REQ-024 SHALL assert rd_valid exactly one cycle after each cycle with rd_en = 1; otherwise rd_valid = 0.
REQ-025 SHALL hold lout/rout at their last values when rd_en = 0.
REQ-026 SHALL treat any index >= DEPTH as out of range: write ignored, that read port registers 0.
REQ-027 SHALL pulse addr_err for one cycle, the cycle after any out-of-range wr_en write or rd_en read.
REQ-028 SHALL increment fill_cnt by 1 on each shift_en while fill_cnt < DEPTH; hold at DEPTH thereafter; addressed writes do not affect it.
REQ-029 SHALL drive full combinationally from fill_cnt.
REQ-030 SHALL allow laddr == raddr; both ports return the same value.
REQ-031 SHALL, when wr_be is all zero, leave the array unchanged and raise no addr_err for an in-range address.

Reset
REQ-032 SHALL, on rst = 1 at a rising clk edge, clear every entry to 0, lout/rout to 0, rd_valid to 0, fill_cnt to 0, addr_err to 0.
REQ-033 SHALL give rst priority over shift_en, wr_en and rd_en in the same cycle; none take effect.
REQ-034 SHALL, on reset asserted mid-operation, discard any read in flight (rd_valid 0 next cycle).

Verification
REQ-035 Bench SHALL cover: reset, then rd_en with laddr=0, raddr=7 -> next cycle lout=0, rout=0, rd_valid=1, fill_cnt=0.
REQ-036 Bench SHALL cover: shift 0x0001..0x0009 on nine cycles -> entry0=0x0009, entry7=0x0002; fill_cnt 8 after 8th shift, stays 8; full=1.
REQ-037 Bench SHALL cover: entry3=0xABCD, wr_en addr 3, wr_data 0x1234, wr_be=2'b01 -> entry3=0xAB34; wr_be=2'b10 then -> 0x1234.
REQ-038 Bench SHALL cover: same cycle shift_en (shift_in 0x5555) and wr_en addr 0 data 0xAAAA be 2'b11, plus rd_en laddr 0 -> lout returns old entry0; afterwards entry0=0xAAAA, entry1=old entry0.
REQ-039 Bench SHALL cover: DEPTH=6, ADDR_W=3, write addr 6 and read raddr 7 -> array unchanged, rout=0, addr_err pulses one cycle.
REQ-040 Bench SHALL cover: rst asserted together with shift_en, wr_en, rd_en after fill -> all entries 0, fill_cnt=0, full=0, rd_valid=0 next cycle.

Source files
------------

// File: rtl/fir_tap_regfile.sv
// rtl/fir_tap_regfile.sv - FIR tap register file: shifting delay line with byte-lane writes and dual read ports
module fir_tap_regfile #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [DATA_W/8-1:0] wr_be,
    input  logic                shift_en,
    input  logic [DATA_W-1:0]   shift_in,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   laddr,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [DATA_W-1:0]   lout,
    output logic [DATA_W-1:0]   rout,
    output logic                rd_valid,
    output logic [ADDR_W:0]     fill_cnt,
    output logic                full,
    output logic                addr_err
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] lout_q, lout_d, rout_q, rout_d;
    logic              rd_valid_q, addr_err_q, addr_err_d;
    logic [ADDR_W:0]   fill_q, fill_d;
    logic              wr_ok, l_ok, r_ok;

    assign wr_ok = {1'b0, wr_addr} < DEPTH_C;
    assign l_ok  = {1'b0, laddr} < DEPTH_C;
    assign r_ok  = {1'b0, raddr} < DEPTH_C;

    // Shift is applied first so an addressed write lands on the post-shift entry.
    always_comb begin
        mem_d = mem_q;
        if (shift_en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                mem_d[i] = mem_q[i-1];
            end
            mem_d[0] = shift_in;
        end
        if (wr_en && wr_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_addr == ADDR_W'(i)) begin
                    for (int b = 0; b < NB; b++) begin
                        if (wr_be[b]) begin
                            mem_d[i][8*b +: 8] = wr_data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // Reads sample pre-edge contents; an out-of-range index yields zero on that port.
    always_comb begin
        lout_d = lout_q;
        rout_d = rout_q;
        if (rd_en) begin
            lout_d = '0;
            rout_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (laddr == ADDR_W'(i)) lout_d = mem_q[i];
                if (raddr == ADDR_W'(i)) rout_d = mem_q[i];
            end
        end
    end

    always_comb begin
        fill_d = fill_q;
        if (shift_en && (fill_q < DEPTH_C)) begin
            fill_d = fill_q + (ADDR_W + 1)'(1);
        end
        addr_err_d = (wr_en && !wr_ok) || (rd_en && (!l_ok || !r_ok));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            lout_q     <= '0;
            rout_q     <= '0;
            rd_valid_q <= 1'b0;
            fill_q     <= '0;
            addr_err_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            lout_q     <= lout_d;
            rout_q     <= rout_d;
            rd_valid_q <= rd_en;
            fill_q     <= fill_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign lout     = lout_q;
    assign rout     = rout_q;
    assign rd_valid = rd_valid_q;
    assign fill_cnt = fill_q;
    assign full     = (fill_q == DEPTH_C);
    assign addr_err = addr_err_q;
endmodule

// File: tb/tb_fir_tap_regfile.sv
// tb/tb_fir_tap_regfile.sv - self-checking bench for fir_tap_regfile against a queue-based model
module tb_fir_tap_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, shift_en, rd_en;
    logic [2:0]  wr_addr, laddr, raddr;
    logic [15:0] wr_data, shift_in;
    logic [1:0]  wr_be;
    logic [15:0] lout, rout;
    logic        rd_valid, full, addr_err;
    logic [3:0]  fill_cnt;

    logic        wr_en6, shift_en6, rd_en6;
    logic [2:0]  wr_addr6, laddr6, raddr6;
    logic [15:0] wr_data6, shift_in6;
    logic [1:0]  wr_be6;
    logic [15:0] lout6, rout6;
    logic        rd_valid6, full6, addr_err6;
    logic [3:0]  fill_cnt6;

    int n_pass = 0;
    int n_total = 0;

    logic [15:0] mq[$];
    logic [15:0] exp_l, exp_r;
    logic        exp_v;
    logic [3:0]  exp_fill;

    always #5 clk = ~clk;

    fir_tap_regfile #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_be(wr_be), .shift_en(shift_en), .shift_in(shift_in), .rd_en(rd_en),
        .laddr(laddr), .raddr(raddr), .lout(lout), .rout(rout), .rd_valid(rd_valid),
        .fill_cnt(fill_cnt), .full(full), .addr_err(addr_err)
    );

    fir_tap_regfile #(.DATA_W(16), .DEPTH(6), .ADDR_W(3)) dut6 (
        .clk(clk), .rst(rst), .wr_en(wr_en6), .wr_addr(wr_addr6), .wr_data(wr_data6),
        .wr_be(wr_be6), .shift_en(shift_en6), .shift_in(shift_in6), .rd_en(rd_en6),
        .laddr(laddr6), .raddr(raddr6), .lout(lout6), .rout(rout6), .rd_valid(rd_valid6),
        .fill_cnt(fill_cnt6), .full(full6), .addr_err(addr_err6)
    );

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) mq.push_back(16'h0000);
        exp_l = 16'h0; exp_r = 16'h0; exp_v = 1'b0; exp_fill = 4'd0;
    endtask

    task automatic cyc(input bit sh, input logic [15:0] sin, input bit we, input logic [2:0] wa,
                       input logic [15:0] wd, input logic [1:0] be, input bit re,
                       input logic [2:0] la, input logic [2:0] ra);
        logic [15:0] mask;
        shift_en = sh; shift_in = sin; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
        rd_en = re; laddr = la; raddr = ra;
        if (re) begin exp_l = mq[la]; exp_r = mq[ra]; end
        exp_v = re;
        if (sh) begin
            mq.push_front(sin);
            void'(mq.pop_back());
            if (exp_fill < 4'd8) exp_fill = exp_fill + 4'd1;
        end
        if (we) begin
            mask = {{8{be[1]}}, {8{be[0]}}};
            mq[wa] = (mq[wa] & ~mask) | (wd & mask);
        end
        @(posedge clk); #1;
        shift_en = 0; wr_en = 0; rd_en = 0; wr_be = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        n_total++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b want 0", rd_valid); else n_pass++;
        n_total++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err got %b want 0", addr_err); else n_pass++;
        n_total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd0, 3'd7);
        n_total++; if (lout !== 16'h0 || rout !== 16'h0) $display("FAIL reset_read got %h/%h want 0000/0000", lout, rout); else n_pass++;
        n_total++; if (rd_valid !== 1'b1) $display("FAIL reset_read_valid got %b want 1", rd_valid); else n_pass++;
        n_total++; if (fill_cnt !== 4'd0) $display("FAIL reset_fill got %0d want 0", fill_cnt); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 0, 3'd0, 3'd0);
        n_total++; if (rd_valid !== 1'b0) $display("FAIL rd_valid_drop got %b want 0", rd_valid); else n_pass++;
    endtask

    task automatic test_shift();
        for (int k = 1; k <= 9; k++) begin
            cyc(1, 16'(k), 0, 0, 0, 0, 0, 0, 0);
            n_total++;
            if (fill_cnt !== ((k < 8) ? 4'(k) : 4'd8)) $display("FAIL shift_fill_%0d got %0d want %0d", k, fill_cnt, (k < 8) ? k : 8);
            else n_pass++;
        end
        n_total++; if (full !== 1'b1) $display("FAIL shift_full got %b want 1", full); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd0, 3'd7);
        n_total++; if (lout !== 16'h0009) $display("FAIL shift_entry0 got %h want 0009", lout); else n_pass++;
        n_total++; if (rout !== 16'h0002) $display("FAIL shift_entry7 got %h want 0002", rout); else n_pass++;
        n_total++; if (lout !== exp_l || rout !== exp_r) $display("FAIL shift_model got %h/%h want %h/%h", lout, rout, exp_l, exp_r); else n_pass++;
    endtask

    task automatic test_byte_write();
        cyc(0, 0, 1, 3'd3, 16'hABCD, 2'b11, 0, 0, 0);
        cyc(0, 0, 1, 3'd3, 16'h1234, 2'b01, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd3, 3'd3);
        n_total++; if (lout !== 16'hAB34 || rout !== 16'hAB34) $display("FAIL be_low got %h/%h want ab34", lout, rout); else n_pass++;
        cyc(0, 0, 1, 3'd3, 16'h1234, 2'b10, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd3, 3'd2);
        n_total++; if (lout !== 16'h1234) $display("FAIL be_high got %h want 1234", lout); else n_pass++;
        n_total++; if (rout !== exp_r) $display("FAIL be_neighbour got %h want %h", rout, exp_r); else n_pass++;
        cyc(0, 0, 1, 3'd3, 16'hFFFF, 2'b00, 0, 0, 0);
        n_total++; if (addr_err !== 1'b0) $display("FAIL be_zero_err got %b want 0", addr_err); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd3, 3'd3);
        n_total++; if (lout !== 16'h1234) $display("FAIL be_zero got %h want 1234", lout); else n_pass++;
    endtask

    task automatic test_shift_write();
        cyc(1, 16'h5555, 1, 3'd0, 16'hAAAA, 2'b11, 1, 3'd0, 3'd1);
        n_total++; if (lout !== 16'h0009) $display("FAIL sw_read_old got %h want 0009", lout); else n_pass++;
        cyc(0, 0, 0, 0, 0, 0, 1, 3'd0, 3'd1);
        n_total++; if (lout !== 16'hAAAA) $display("FAIL sw_entry0 got %h want aaaa", lout); else n_pass++;
        n_total++; if (rout !== 16'h0009) $display("FAIL sw_entry1 got %h want 0009", rout); else n_pass++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            cyc($urandom_range(0, 1), 16'($urandom), ($urandom_range(0, 2) == 0), 3'($urandom),
                16'($urandom), 2'($urandom), ($urandom_range(0, 1) == 1), 3'($urandom), 3'($urandom));
            n_total++;
            if (lout !== exp_l || rout !== exp_r || rd_valid !== exp_v)
                $display("FAIL rand_read_%0d got %h/%h/%b want %h/%h/%b", n, lout, rout, rd_valid, exp_l, exp_r, exp_v);
            else n_pass++;
            n_total++;
            if (fill_cnt !== exp_fill || full !== (exp_fill == 4'd8) || addr_err !== 1'b0)
                $display("FAIL rand_status_%0d got %0d/%b/%b want %0d/%b/0", n, fill_cnt, full, addr_err, exp_fill, exp_fill == 4'd8);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        shift_en6 = 1; shift_in6 = 16'h0011;
        @(posedge clk); #1;
        shift_in6 = 16'h0022;
        @(posedge clk); #1;
        shift_en6 = 0;
        wr_en6 = 1; wr_addr6 = 3'd6; wr_data6 = 16'hFFFF; wr_be6 = 2'b11;
        rd_en6 = 1; laddr6 = 3'd0; raddr6 = 3'd7;
        @(posedge clk); #1;
        wr_en6 = 0; rd_en6 = 0;
        n_total++; if (rout6 !== 16'h0) $display("FAIL oob_rout got %h want 0000", rout6); else n_pass++;
        n_total++; if (lout6 !== 16'h0022) $display("FAIL oob_lout got %h want 0022", lout6); else n_pass++;
        n_total++; if (addr_err6 !== 1'b1) $display("FAIL oob_err_pulse got %b want 1", addr_err6); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (addr_err6 !== 1'b0) $display("FAIL oob_err_clear got %b want 0", addr_err6); else n_pass++;
        rd_en6 = 1; laddr6 = 3'd1; raddr6 = 3'd5;
        @(posedge clk); #1;
        rd_en6 = 0;
        n_total++; if (lout6 !== 16'h0011 || rout6 !== 16'h0) $display("FAIL oob_array got %h/%h want 0011/0000", lout6, rout6); else n_pass++;
        n_total++; if (fill_cnt6 !== 4'd2 || addr_err6 !== 1'b0) $display("FAIL oob_fill got %0d/%b want 2/0", fill_cnt6, addr_err6); else n_pass++;
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 8; k++) cyc(1, 16'h1000 + 16'(k), 0, 0, 0, 0, 0, 0, 0);
        n_total++; if (full !== 1'b1) $display("FAIL mid_prefull got %b want 1", full); else n_pass++;
        rst = 1'b1;
        shift_en = 1; shift_in = 16'hBEEF; wr_en = 1; wr_addr = 3'd2; wr_data = 16'hCAFE; wr_be = 2'b11;
        rd_en = 1; laddr = 3'd0; raddr = 3'd7;
        @(posedge clk); #1;
        rst = 1'b0; shift_en = 0; wr_en = 0; rd_en = 0;
        model_reset();
        n_total++; if (fill_cnt !== 4'd0 || full !== 1'b0) $display("FAIL mid_fill got %0d/%b want 0/0", fill_cnt, full); else n_pass++;
        n_total++; if (rd_valid !== 1'b0 || lout !== 16'h0 || rout !== 16'h0) $display("FAIL mid_read got %b/%h/%h want 0/0000/0000", rd_valid, lout, rout); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 3'(2 * k), 3'(2 * k + 1));
            n_total++;
            if (lout !== 16'h0 || rout !== 16'h0) $display("FAIL mid_entries_%0d got %h/%h want 0000/0000", k, lout, rout);
            else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1;
        wr_en = 0; shift_en = 0; rd_en = 0; wr_addr = 0; laddr = 0; raddr = 0;
        wr_data = 0; shift_in = 0; wr_be = 0;
        wr_en6 = 0; shift_en6 = 0; rd_en6 = 0; wr_addr6 = 0; laddr6 = 0; raddr6 = 0;
        wr_data6 = 0; shift_in6 = 0; wr_be6 = 0;
        @(posedge clk); #1;
        test_reset();
        test_shift();
        test_byte_write();
        test_shift_write();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
